// File: rtl/fxp_pkg.sv
// fxp_pkg: shared Q16.16 fixed-point definitions for the rasterizer
// arithmetic units and the sqrt state encoding.
//   fxp_t          : 32-bit signed Q16.16 word
//   sqrt_state_e   : fxp_sqrt_iter controller states
//   SQRT_* widths  : root (24), remainder (26) and radicand (48) widths
package fxp_pkg;

  typedef logic [31:0] fxp_t;

  localparam int unsigned FXP_FRAC_BITS  = 16;
  localparam int unsigned FXP_INT_BITS   = 16;

  localparam int unsigned SQRT_ROOT_BITS = 24;
  // Remainder is bounded by 2*q, so two bits over the root width is enough.
  localparam int unsigned SQRT_REM_BITS  = SQRT_ROOT_BITS + 2;
  localparam int unsigned SQRT_RAD_BITS  = 2 * SQRT_ROOT_BITS;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } sqrt_state_e;

endpackage

// File: rtl/fxp_sqrt_iter_if.sv
// fxp_sqrt_iter_if: operand/result handshake bundle for fxp_sqrt_iter.
//   in_valid/in_ready/dataa      : operand channel (source -> sqrt)
//   out_valid/out_ready/result/neg_err : result channel (sqrt -> consumer)
//   modport slave  : the sqrt unit
//   modport master : the surrounding datapath
interface fxp_sqrt_iter_if;
  import fxp_pkg::*;

  logic in_valid;
  logic in_ready;
  fxp_t dataa;
  logic out_valid;
  logic out_ready;
  fxp_t result;
  logic neg_err;

  modport slave (
    input  in_valid, dataa, out_ready,
    output in_ready, out_valid, result, neg_err
  );

  modport master (
    output in_valid, dataa, out_ready,
    input  in_ready, out_valid, result, neg_err
  );

endinterface

// File: rtl/fxp_sqrt_step.sv
// fxp_sqrt_step: one combinational restoring square-root digit step.
//   rem_i  : running remainder
//   q_i    : partial root
//   bits_i : next two radicand bits, MSB first
//   rem_o  : updated remainder
//   q_o    : partial root with the new bit appended
module fxp_sqrt_step
  import fxp_pkg::*;
(
  input  logic [SQRT_REM_BITS-1:0]  rem_i,
  input  logic [SQRT_ROOT_BITS-1:0] q_i,
  input  logic [1:0]                bits_i,
  output logic [SQRT_REM_BITS-1:0]  rem_o,
  output logic [SQRT_ROOT_BITS-1:0] q_o
);

  logic [SQRT_REM_BITS+1:0] acc;
  logic [SQRT_REM_BITS+1:0] sub;
  logic                     ge;

  always_comb begin
    acc = {rem_i, bits_i};
    sub = {{(SQRT_REM_BITS - SQRT_ROOT_BITS){1'b0}}, q_i, 2'b01};
    ge  = (acc >= sub);
    // Both branches fit the remainder width: acc < sub when restoring,
    // and acc - sub <= 2*q otherwise.
    rem_o = ge ? SQRT_REM_BITS'(acc - sub) : SQRT_REM_BITS'(acc);
    q_o   = {q_i[SQRT_ROOT_BITS-2:0], ge};
  end

endmodule

// File: rtl/fxp_sqrt_iter.sv
// fxp_sqrt_iter: multi-cycle, non-pipelined unsigned square root of a
// Q16.16 operand. Radicand {dataa, 16'b0} yields a 24-bit root in Q16.16.
//   clock  : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : fxp_sqrt_iter_if.slave (operand and result handshakes)
// Parameter BITS_PER_CYCLE (1,2,3,4,6,8) sets root bits resolved per cycle.
// Define FXP_SQRT_ROUND_EN for round-to-nearest; default is truncation.
module fxp_sqrt_iter
  import fxp_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic           clock,
  input  logic           reset,
  fxp_sqrt_iter_if.slave bus
);

  localparam int unsigned ITER  = SQRT_ROOT_BITS / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  sqrt_state_e               state_q, state_d;
  logic [SQRT_RAD_BITS-1:0]  rad_q,   rad_d;
  logic [SQRT_REM_BITS-1:0]  rem_q,   rem_d;
  logic [SQRT_ROOT_BITS-1:0] root_q,  root_d;
  logic [CNT_W-1:0]          cnt_q,   cnt_d;
  fxp_t                      res_q,   res_d;
  logic                      neg_q,   neg_d;

  logic [SQRT_REM_BITS-1:0]  rem_step;
  logic [SQRT_ROOT_BITS-1:0] q_step;
  logic [SQRT_ROOT_BITS-1:0] root_fin;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    logic [SQRT_REM_BITS-1:0]  rem_in;
    logic [SQRT_ROOT_BITS-1:0] q_in;
    logic [SQRT_REM_BITS-1:0]  rem_out;
    logic [SQRT_ROOT_BITS-1:0] q_out;

    if (i == 0) begin : g_first
      assign rem_in = rem_q;
      assign q_in   = root_q;
    end else begin : g_next
      assign rem_in = g_step[i-1].rem_out;
      assign q_in   = g_step[i-1].q_out;
    end

    fxp_sqrt_step u_step (
      .rem_i  (rem_in),
      .q_i    (q_in),
      .bits_i (rad_q[SQRT_RAD_BITS-1-2*i -: 2]),
      .rem_o  (rem_out),
      .q_o    (q_out)
    );
  end

  assign rem_step = g_step[BITS_PER_CYCLE-1].rem_out;
  assign q_step   = g_step[BITS_PER_CYCLE-1].q_out;

  always_comb begin
    root_fin = q_step;
`ifdef FXP_SQRT_ROUND_EN
    // R - q^2 equals the final remainder, so rem > q means the true root
    // is nearer q+1; q is at most 0xB504F3, so the increment cannot wrap.
    if (rem_step > SQRT_REM_BITS'(q_step)) begin
      root_fin = q_step + 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    neg_d   = neg_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          rad_d  = {bus.dataa, {FXP_FRAC_BITS{1'b0}}};
          rem_d  = '0;
          root_d = '0;
          cnt_d  = '0;
          neg_d  = bus.dataa[31];
          if (bus.dataa[31]) begin
            res_d   = '0;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rad_d  = rad_q << (2 * BITS_PER_CYCLE);
        rem_d  = rem_step;
        root_d = q_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          res_d   = {{($bits(fxp_t) - SQRT_ROOT_BITS){1'b0}}, root_fin};
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.neg_err   = neg_q;

endmodule

// File: tb/tb_fxp_sqrt_iter.sv
module tb_fxp_sqrt_iter;

  logic clock = 1'b0;
  logic rst1  = 1'b1;
  logic rst4  = 1'b1;

  int unsigned nerr   = 0;
  int unsigned nchecks = 0;

  always #5 clock = ~clock;

  fxp_sqrt_iter_if b1 ();
  fxp_sqrt_iter_if b4 ();

  fxp_sqrt_iter #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clock (clock),
    .reset (rst1),
    .bus   (b1.slave)
  );

  fxp_sqrt_iter #(.BITS_PER_CYCLE(4)) u_dut4 (
    .clock (clock),
    .reset (rst4),
    .bus   (b4.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned iter_of(input int s);
    return (s == 0) ? 24 : 6;
  endfunction

  task automatic set_in(input int s, input logic v, input logic [31:0] d, input logic r);
    if (s == 0) begin
      b1.in_valid = v; b1.dataa = d; b1.out_ready = r;
    end else begin
      b4.in_valid = v; b4.dataa = d; b4.out_ready = r;
    end
  endtask

  task automatic set_rst(input int s, input logic v);
    if (s == 0) rst1 = v;
    else        rst4 = v;
  endtask

  task automatic get_out(input int s, output logic iv, output logic ov,
                         output logic [31:0] r, output logic ne);
    if (s == 0) begin
      iv = b1.in_ready; ov = b1.out_valid; r = b1.result; ne = b1.neg_err;
    end else begin
      iv = b4.in_ready; ov = b4.out_valid; r = b4.result; ne = b4.neg_err;
    end
  endtask

  // Reference: real-valued sqrt, then exact integer correction to floor.
  function automatic logic [31:0] model_sqrt(input logic [31:0] d, output logic neg);
    longint unsigned rad;
    longint unsigned q;
    neg = d[31];
    if (neg) return 32'd0;
    rad = longint'(d) * 64'd65536;
    q = longint'($floor($sqrt(real'(rad))));
    while (q * q > rad) q--;
    while ((q + 1) * (q + 1) <= rad) q++;
`ifdef FXP_SQRT_ROUND_EN
    if (rad - q * q > q) q++;
`endif
    return 32'(q);
  endfunction

  task automatic run_op(input int s, input logic [31:0] d, input logic [31:0] exp_res,
                        input logic exp_neg, input int unsigned hold);
    int unsigned n;
    int unsigned lat;
    logic iv, ov, ne;
    logic [31:0] r, r_held;
    lat = exp_neg ? 1 : iter_of(s) + 1;
    get_out(s, iv, ov, r, ne);
    check($sformatf("in_ready_idle[%0d]", s), {31'b0, iv}, 32'd1);
    set_in(s, 1'b1, d, hold == 0);
    @(posedge clock); #1;
    n = 1;
    set_in(s, 1'b0, 32'd0, hold == 0);
    get_out(s, iv, ov, r, ne);
    while (!ov && n < 60) begin
      @(posedge clock); #1;
      n++;
      get_out(s, iv, ov, r, ne);
    end
    check($sformatf("latency[%0d] %h", s, d), n, lat);
    check($sformatf("result[%0d] %h", s, d), r, exp_res);
    check($sformatf("neg_err[%0d] %h", s, d), {31'b0, ne}, {31'b0, exp_neg});
    r_held = r;
    for (int unsigned k = 0; k < hold; k++) begin
      set_in(s, 1'b1, d ^ 32'h00F0_0000, 1'b0);
      @(posedge clock); #1;
      get_out(s, iv, ov, r, ne);
      check($sformatf("bp_valid[%0d]", s), {31'b0, ov}, 32'd1);
      check($sformatf("bp_result[%0d]", s), r, r_held);
      check($sformatf("bp_in_ready[%0d]", s), {31'b0, iv}, 32'd0);
    end
    // Operand offered in the handshake cycle must be ignored.
    if (hold > 0) set_in(s, 1'b1, 32'h0123_0000, 1'b1);
    @(posedge clock); #1;
    get_out(s, iv, ov, r, ne);
    check($sformatf("hs_valid_low[%0d]", s), {31'b0, ov}, 32'd0);
    check($sformatf("hs_in_ready[%0d]", s), {31'b0, iv}, 32'd1);
    set_in(s, 1'b0, 32'd0, 1'b1);
  endtask

  task automatic run_model(input int s, input logic [31:0] d, input int unsigned hold);
    logic ne;
    logic [31:0] e;
    e = model_sqrt(d, ne);
    run_op(s, d, e, ne, hold);
  endtask

  initial begin
    logic iv, ov, ne;
    logic [31:0] r;
    logic [31:0] d;
    logic [31:0] two_exp;

`ifdef FXP_SQRT_ROUND_EN
    two_exp = 32'h0001_6A0A;
`else
    two_exp = 32'h0001_6A09;
`endif

    set_in(0, 1'b0, 32'd0, 1'b1);
    set_in(1, 1'b0, 32'd0, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    rst1 = 1'b0;
    rst4 = 1'b0;

    for (int s = 0; s < 2; s++) begin
      get_out(s, iv, ov, r, ne);
      check($sformatf("rst_in_ready[%0d]", s), {31'b0, iv}, 32'd1);
      check($sformatf("rst_out_valid[%0d]", s), {31'b0, ov}, 32'd0);
      check($sformatf("rst_result[%0d]", s), r, 32'd0);
      check($sformatf("rst_neg_err[%0d]", s), {31'b0, ne}, 32'd0);

      run_op(s, 32'h0004_0000, 32'h0002_0000, 1'b0, 0);
      run_op(s, 32'h0002_0000, two_exp,       1'b0, 0);
      run_op(s, 32'h0000_4000, 32'h0000_8000, 1'b0, 0);
      run_op(s, 32'h0000_0000, 32'h0000_0000, 1'b0, 0);
      run_op(s, 32'h7FFF_FFFF, 32'h00B5_04F3, 1'b0, 0);
      run_op(s, 32'h8000_0000, 32'h0000_0000, 1'b1, 0);
      run_op(s, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);

      // Backpressure then back-to-back operand.
      run_op(s, 32'h0010_0000, 32'h0004_0000, 1'b0, 10);
      run_op(s, 32'h0009_0000, 32'h0003_0000, 1'b0, 0);

      // Reset during the fifth CALC cycle discards the operation.
      set_in(s, 1'b1, 32'h0005_0000, 1'b1);
      @(posedge clock); #1;
      set_in(s, 1'b0, 32'd0, 1'b1);
      repeat (4) @(posedge clock);
      #1;
      set_rst(s, 1'b1);
      @(posedge clock); #1;
      set_rst(s, 1'b0);
      get_out(s, iv, ov, r, ne);
      check($sformatf("mid_rst_out_valid[%0d]", s), {31'b0, ov}, 32'd0);
      check($sformatf("mid_rst_in_ready[%0d]", s), {31'b0, iv}, 32'd1);
      check($sformatf("mid_rst_result[%0d]", s), r, 32'd0);
      for (int unsigned k = 0; k < iter_of(s) + 3; k++) begin
        @(posedge clock); #1;
        get_out(s, iv, ov, r, ne);
        check($sformatf("post_rst_quiet[%0d]", s), {31'b0, ov}, 32'd0);
      end
      run_op(s, 32'h0001_0000, 32'h0001_0000, 1'b0, 0);

      for (int k = 0; k < 20; k++) begin
        d = $urandom;
        if (k % 5 != 4) d[31] = 1'b0;
        run_model(s, d, (k % 7 == 3) ? 2 : 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

  initial begin
    #2_000_000;
    nerr++;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fxp_sqrt_iter.md
Name: fxp_sqrt_iter

Overview:
- Iterative unsigned square root for the Q16.16 fixed-point format used by FXPAddSub/FXPMult/FXPDiv. It is the inverse direction of FXPMult squaring.
- Sits beside the arithmetic units in the rasterizer datapath, e.g. for vector-length normalisation.
- Unlike the fixed-latency pipelined units, it is multi-cycle, non-pipelined, and uses valid/ready handshakes on input and output.

Parameters:
- BITS_PER_CYCLE, 1, root bits resolved per CALC cycle; legal values 1, 2, 3, 4, 6, 8 (must divide 24).
- ITER (localparam), 24/BITS_PER_CYCLE, number of CALC cycles.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- dataa  in  32  operand, signed Q16.16.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  32  sqrt(dataa), Q16.16, upper 8 bits always 0.
- neg_err  out  1  operand was negative; qualified by out_valid.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, neg_err=0, internal radicand/remainder/root=0.
- Math: radicand R = {dataa, 16'b0} (48 bits); root q = floor(sqrt(R)) (24 bits); result = {8'b0, q}.
- Step: restoring digit-by-digit, MSB first. Per bit: trial = (rem<<2 | next 2 radicand bits) - (q<<2 | 1). If trial ≥ 0, rem=trial and append root bit 1; else append 0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid: latch dataa, clear rem/q, go to CALC.
  - If dataa[31]=1: skip CALC, go to DONE with result=0, neg_err=1.
- FSM CALC:
  - in_ready=0; resolves BITS_PER_CYCLE root bits per cycle.
  - After ITER cycles, go to DONE.
- FSM DONE:
  - out_valid=1; result and neg_err are held stable until out_ready.
  - On out_valid&&out_ready: return to IDLE, out_valid=0 next cycle.
- Latency: accept edge to out_valid high is ITER+1 edges (25 for BITS_PER_CYCLE=1). Negative operand: 1 edge.
- Throughput: one operation per ITER+2 cycles minimum. No new operand is accepted until the result handshake completes, including the same-cycle case.
- Backpressure: out_ready low holds DONE indefinitely, with no change to outputs.
- Zero: dataa=0 yields result=0, neg_err=0 after full latency (no early-out).
- Max: dataa=0x7FFFFFFF gives q=0xB504F3. The 24-bit root never overflows.
- Reset mid-CALC or mid-DONE: next cycle is IDLE with reset values. The pending result is discarded and no out_valid pulse occurs.
- in_valid while busy is ignored (in_ready=0). The source must hold its operand.

Optional Feature:
- FXP_SQRT_ROUND_EN defined: round-to-nearest at DONE entry. If final rem > q, then q = q+1 (i.e. R - q² > q). Adds no latency cycle; the increment is registered on the CALC→DONE transition.
- Undefined: truncation (floor), result exactly floor(sqrt(R)).
- neg_err behaviour is identical in both builds.

Decomposition:
- Package fxp_pkg:
  - typedef fxp_t (logic [31:0]).
  - FXP_FRAC_BITS=16, FXP_INT_BITS=16.
  - sqrt state enum {IDLE, CALC, DONE}.
  - SQRT_ROOT_BITS=24.
- Sub-module fxp_sqrt_step: combinational single-bit restoring step.
  - Inputs: rem, q, next two radicand bits.
  - Outputs: new rem, new q.
  - Chained BITS_PER_CYCLE times in a generate loop inside fxp_sqrt_iter.

Test Plan:
- dataa=0x00040000 (4.0), out_ready=1 -> after 25 edges out_valid=1, result=0x00020000, neg_err=0.
- dataa=0x00020000 (2.0) -> result=0x00016A09 truncated; 0x00016A0A with FXP_SQRT_ROUND_EN.
- dataa=0x00004000 (0.25) -> result=0x00008000. dataa=0 -> result=0 after full latency.
- dataa=0x7FFFFFFF -> result=0x00B504F3. dataa=0x80000000 -> out_valid after 1 edge, result=0, neg_err=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> result/out_valid stable, in_ready=0. Then out_ready=1 -> IDLE next cycle, and a back-to-back operand 0x00090000 gives 0x00030000.
- Reset asserted at CALC cycle 5 -> next cycle out_valid=0, in_ready=1. New dataa=0x00010000 gives 0x00010000. Repeat all cases with BITS_PER_CYCLE=4 (latency 7 edges).
